// File: rtl/pe_mac_vec_if.sv
// pe_mac_vec_if: job/operand bus for the vector MAC processing element.
//   master (operand fetch side) drives: start, len, sat_en, relu_en, ready,
//                                       in_data1, in_data2
//   slave  (pe_mac_vec) drives:         outdata, done, busy
// Lane i of in_data1/in_data2 sits at bits [i*DATA_W +: DATA_W].
interface pe_mac_vec_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    sat_en;
    logic                    relu_en;
    logic                    ready;
    logic [LANES*DATA_W-1:0] in_data1;
    logic [LANES*DATA_W-1:0] in_data2;
    logic [ACC_W-1:0]        outdata;
    logic                    done;
    logic                    busy;

    modport master (
        output start, len, sat_en, relu_en, ready, in_data1, in_data2,
        input  outdata, done, busy
    );

    modport slave (
        input  start, len, sat_en, relu_en, ready, in_data1, in_data2,
        output outdata, done, busy
    );
endinterface

// File: rtl/pe_mac_vec.sv
// pe_mac_vec: vector multiply-accumulate processing element.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : pe_mac_vec_if.slave (job control, operand lanes, result/done/busy)
// Pipeline: accept edge registers per-lane products (stage 1), the next edge
// registers the lane sum (stage 2), the edge after that folds the sum into the
// accumulator with optional saturation (stage 3). The last beat of a job
// publishes the result (optionally ReLU-clamped) with a one-cycle done.

// One multiplier lane: registered signed product.
module pe_mac_lane #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] prod
);
    logic [2*DATA_W-1:0] a_x, b_x;

    // Low 2*DATA_W bits of the product of sign-extended operands are the exact
    // signed product.
    assign a_x = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_x = {{DATA_W{b[DATA_W-1]}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= '0;
        else if (en)
            prod <= a_x * b_x;
    end
endmodule

module pe_mac_vec #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    pe_mac_vec_if.slave  bus
);
    localparam int P_W   = 2 * DATA_W;
    localparam int SUM_W = P_W + $clog2(LANES);

    logic [LEN_W-1:0]            len_q, cnt;
    logic                        sat_q, relu_q, busy_q, done_q;
    logic [2:1]                  vld_pipe;
    logic [2:1]                  last_pipe;   // marks the job's final beat
    logic [LANES-1:0][P_W-1:0]   prod;
    logic signed [SUM_W-1:0]     sum_c, sum_q;
    logic [ACC_W-1:0]            acc, acc_nxt, res, outdata_q;
    logic [ACC_W:0]              acc_wide;
    logic                        accept, last_beat, ovf;

    // A start in the same cycle flushes everything, so a concurrent beat is
    // simply not taken.
    assign accept    = busy_q && bus.ready && (cnt < len_q) && !bus.start;
    assign last_beat = (cnt == len_q - LEN_W'(1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_mac_lane #(.DATA_W(DATA_W)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (accept),
            .a    (bus.in_data1[i*DATA_W +: DATA_W]),
            .b    (bus.in_data2[i*DATA_W +: DATA_W]),
            .prod (prod[i])
        );
    end

    // Lane reduction; SUM_W holds LANES worst-case products without overflow.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++)
            sum_c = sum_c + SUM_W'($signed(prod[i]));
    end

    // One extra bit exposes accumulator overflow: top two bits differ.
    always_comb begin
        acc_wide = {acc[ACC_W-1], acc} + (ACC_W+1)'(sum_q);
        ovf      = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
        if (sat_q && ovf)
            acc_nxt = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_nxt = acc_wide[ACC_W-1:0];
        res = (relu_q && acc_nxt[ACC_W-1]) ? '0 : acc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            cnt       <= '0;
            sat_q     <= 1'b0;
            relu_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            sum_q     <= '0;
            acc       <= '0;
            outdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (vld_pipe[1])
                sum_q <= sum_c;
            if (bus.start) begin
                // New job (or abort of the running one): drop in-flight beats.
                len_q     <= bus.len;
                sat_q     <= bus.sat_en;
                relu_q    <= bus.relu_en;
                cnt       <= '0;
                acc       <= '0;
                vld_pipe  <= '0;
                last_pipe <= '0;
                busy_q    <= (bus.len != '0);
                if (bus.len == '0) begin
                    outdata_q <= '0;
                    done_q    <= 1'b1;
                end
            end else begin
                vld_pipe  <= {vld_pipe[1], accept};
                last_pipe <= {last_pipe[1], accept && last_beat};
                if (accept)
                    cnt <= cnt + LEN_W'(1);
                if (vld_pipe[2]) begin
                    acc <= acc_nxt;
                    if (last_pipe[2]) begin
                        outdata_q <= res;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.outdata = outdata_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
endmodule
